// File: rtl/dmac_mc_master.sv
// Multi-channel AHB-Lite DMA master: NCH channel contexts share one bus port.
// Arbitration is round-robin per beat, and each beat is one read followed by one write.
module dmac_mc_master #(
  parameter int NCH  = 2,
  parameter int CW   = 8,
  parameter int NIRQ = 8,
  localparam int IW  = (NIRQ > 1) ? $clog2(NIRQ) : 1,
  localparam int GW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic [2:0]        HSIZE,
  output logic              HWRITE,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic [31:0]       HRDATA,
  input  logic [NCH*32-1:0] ch_saddr,
  input  logic [NCH*32-1:0] ch_daddr,
  input  logic [NCH*3-1:0]  ch_ssize,
  input  logic [NCH*3-1:0]  ch_dsize,
  input  logic [NCH*3-1:0]  ch_sinc,
  input  logic [NCH*3-1:0]  ch_dinc,
  input  logic [NCH*CW-1:0] ch_bsize,
  input  logic [NCH*CW-1:0] ch_bcount,
  input  logic [NCH-1:0]    ch_wfi,
  input  logic [NCH*IW-1:0] ch_irqsrc,
  input  logic [NIRQ-1:0]   pirq,
  input  logic [NCH-1:0]    ch_start,
  input  logic [NCH-1:0]    ch_abort,
  output logic [NCH-1:0]    ch_busy,
  output logic [NCH-1:0]    ch_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARB  = 3'd1;
  localparam logic [2:0] S_RA   = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WA   = 3'd4;
  localparam logic [2:0] S_WD   = 3'd5;

  logic [2:0]    state_reg;
  logic [GW-1:0] gnt_reg;
  logic [GW-1:0] rr_reg;
  logic [31:0]   data_reg;

  logic [NCH-1:0] elig;
  logic           any_elig;
  logic [GW-1:0]  sel;
  int             arb_idx;

  logic [31:0] sa_w    [NCH];
  logic [31:0] da_w    [NCH];
  logic [2:0]  ssize_w [NCH];
  logic [2:0]  dsize_w [NCH];

  logic        rd_phase, wr_phase, in_beat, rd_end, beat_end;
  logic [31:0] sa_g;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_aligned;

  assign rd_phase = (state_reg == S_RA) || (state_reg == S_RD);
  assign wr_phase = (state_reg == S_WA) || (state_reg == S_WD);
  assign in_beat  = rd_phase || wr_phase;
  assign rd_end   = (state_reg == S_RD) && HREADY;
  assign beat_end = (state_reg == S_WD) && HREADY;
  assign sa_g     = sa_w[gnt_reg];

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [31:0]   sa_reg, da_reg;
      logic [2:0]    ssize_reg, dsize_reg, sinc_reg, dinc_reg;
      logic [CW-1:0] cb_reg, cr_reg, bsize_reg;
      logic          wfi_reg, busy_reg, abort_pend_reg, done_reg;
      logic [IW-1:0] irqsrc_reg;
      logic          mine;

      assign mine = in_beat && (gnt_reg == GW'(gi));

      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          sa_reg         <= '0;
          da_reg         <= '0;
          ssize_reg      <= '0;
          dsize_reg      <= '0;
          sinc_reg       <= '0;
          dinc_reg       <= '0;
          cb_reg         <= '0;
          cr_reg         <= '0;
          bsize_reg      <= '0;
          wfi_reg        <= 1'b0;
          irqsrc_reg     <= '0;
          busy_reg       <= 1'b0;
          abort_pend_reg <= 1'b0;
          done_reg       <= 1'b0;
        end else begin
          done_reg <= 1'b0;
          if (!busy_reg) begin
            if (ch_start[gi] && !ch_abort[gi]) begin
              sa_reg         <= ch_saddr[32*gi +: 32];
              da_reg         <= ch_daddr[32*gi +: 32];
              ssize_reg      <= ch_ssize[3*gi +: 3];
              dsize_reg      <= ch_dsize[3*gi +: 3];
              sinc_reg       <= ch_sinc[3*gi +: 3];
              dinc_reg       <= ch_dinc[3*gi +: 3];
              cb_reg         <= ch_bsize[CW*gi +: CW];
              bsize_reg      <= ch_bsize[CW*gi +: CW];
              cr_reg         <= ch_bcount[CW*gi +: CW];
              wfi_reg        <= ch_wfi[gi];
              irqsrc_reg     <= ch_irqsrc[IW*gi +: IW];
              busy_reg       <= 1'b1;
              abort_pend_reg <= 1'b0;
            end
          end else if (mine) begin
            // An abort during a beat is deferred so the bus transfer is never truncated.
            if (ch_abort[gi])
              abort_pend_reg <= 1'b1;
            if (rd_end)
              sa_reg <= sa_reg + {29'd0, sinc_reg};
            if (beat_end) begin
              da_reg <= da_reg + {29'd0, dinc_reg};
              if (abort_pend_reg || ch_abort[gi]) begin
                busy_reg       <= 1'b0;
                abort_pend_reg <= 1'b0;
              end else if (cb_reg != '0) begin
                cb_reg <= cb_reg - 1'b1;
              end else if (cr_reg != '0) begin
                cr_reg <= cr_reg - 1'b1;
                cb_reg <= bsize_reg;
              end else begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
              end
            end
          end else if (ch_abort[gi] || abort_pend_reg) begin
            busy_reg       <= 1'b0;
            abort_pend_reg <= 1'b0;
          end
        end
      end

      assign elig[gi]    = busy_reg && !abort_pend_reg && !ch_abort[gi] &&
                           (!wfi_reg || pirq[irqsrc_reg]);
      assign sa_w[gi]    = sa_reg;
      assign da_w[gi]    = da_reg;
      assign ssize_w[gi] = ssize_reg;
      assign dsize_w[gi] = dsize_reg;
      assign ch_busy[gi] = busy_reg;
      assign ch_done[gi] = done_reg;
    end
  endgenerate

  // Scan downwards so the lowest offset from the RR pointer wins.
  always_comb begin
    any_elig = 1'b0;
    sel      = '0;
    arb_idx  = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      arb_idx = (int'(rr_reg) + k) % NCH;
      if (elig[arb_idx]) begin
        any_elig = 1'b1;
        sel      = arb_idx[GW-1:0];
      end
    end
  end

  // Narrow reads are replicated so any destination lane carries the value.
  always_comb begin
    rd_byte = HRDATA[{sa_g[1:0], 3'b000} +: 8];
    rd_half = sa_g[1] ? HRDATA[31:16] : HRDATA[15:0];
    case (ssize_w[gnt_reg])
      3'd0:    rd_aligned = {4{rd_byte}};
      3'd1:    rd_aligned = {2{rd_half}};
      default: rd_aligned = HRDATA;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= S_IDLE;
      gnt_reg   <= '0;
      rr_reg    <= '0;
      data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (any_elig) state_reg <= S_ARB;
        S_ARB: begin
          if (any_elig) begin
            gnt_reg   <= sel;
            rr_reg    <= (int'(sel) == NCH - 1) ? '0 : sel + 1'b1;
            state_reg <= S_RA;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RA: if (HREADY) state_reg <= S_RD;
        S_RD: begin
          if (HREADY) begin
            data_reg  <= rd_aligned;
            state_reg <= S_WA;
          end
        end
        S_WA: if (HREADY) state_reg <= S_WD;
        S_WD: if (HREADY) state_reg <= S_ARB;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign HTRANS = ((state_reg == S_RA) || (state_reg == S_WA)) ? 2'b10 : 2'b00;
  assign HWRITE = wr_phase;
  assign HADDR  = rd_phase ? sa_g : (wr_phase ? da_w[gnt_reg] : 32'h0);
  assign HSIZE  = rd_phase ? ssize_w[gnt_reg] : (wr_phase ? dsize_w[gnt_reg] : 3'b010);
  assign HWDATA = data_reg;

endmodule

// File: tb/tb_dmac_mc_master.sv
// Bench for dmac_mc_master: table of single-channel transfers plus directed
// sequences for round-robin, request gating, wait states, abort and reset.
module tb_dmac_mc_master;
  localparam int NCH = 2, CW = 8, NIRQ = 8, IW = 3;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY = 1'b1;
  logic [NCH*32-1:0] ch_saddr = '0, ch_daddr = '0;
  logic [NCH*3-1:0]  ch_ssize = '0, ch_dsize = '0, ch_sinc = '0, ch_dinc = '0;
  logic [NCH*CW-1:0] ch_bsize = '0, ch_bcount = '0;
  logic [NCH-1:0]    ch_wfi = '0, ch_start = '0, ch_abort = '0, ch_busy, ch_done;
  logic [NCH*IW-1:0] ch_irqsrc = '0;
  logic [NIRQ-1:0]   pirq = '0;

  dmac_mc_master #(.NCH(NCH), .CW(CW), .NIRQ(NIRQ)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .ch_saddr(ch_saddr), .ch_daddr(ch_daddr), .ch_ssize(ch_ssize), .ch_dsize(ch_dsize),
    .ch_sinc(ch_sinc), .ch_dinc(ch_dinc), .ch_bsize(ch_bsize), .ch_bcount(ch_bcount),
    .ch_wfi(ch_wfi), .ch_irqsrc(ch_irqsrc), .pirq(pirq), .ch_start(ch_start),
    .ch_abort(ch_abort), .ch_busy(ch_busy), .ch_done(ch_done)
  );

  always #5 HCLK = ~HCLK;

  // Slave model: pattern data derived from the read address, or a fixed word.
  logic        pat_mode = 1'b1;
  logic [31:0] fixed_rdata = '0;
  logic [31:0] raddr_q = '0;
  assign HRDATA = pat_mode ? (32'hC0DE0000 | {16'h0, raddr_q[15:0]}) : fixed_rdata;

  int cyc = 0;
  always @(posedge HCLK) cyc++;

  logic [31:0] wlog_a[$], wlog_d[$], rlog[$];
  logic [2:0]  wlog_s[$];
  int          ntrans = 0, first_ra = -1;
  int          done_cnt[NCH];
  logic        pend_w = 1'b0;
  logic [31:0] pend_a;
  logic [2:0]  pend_s;

  always @(negedge HCLK) begin
    for (int c = 0; c < NCH; c++) if (ch_done[c]) done_cnt[c]++;
    if (HRESETn && HTRANS == 2'b10 && first_ra < 0) first_ra = cyc;
    if (HRESETn && HREADY) begin
      if (pend_w) begin
        wlog_a.push_back(pend_a); wlog_d.push_back(HWDATA); wlog_s.push_back(pend_s);
        pend_w = 1'b0;
      end
      if (HTRANS == 2'b10) begin
        ntrans++;
        if (HWRITE) begin pend_w = 1'b1; pend_a = HADDR; pend_s = HSIZE; end
        else begin raddr_q = HADDR; rlog.push_back(HADDR); end
      end
    end
    if (!HRESETn) pend_w = 1'b0;
  end

  int total = 0, passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
  endtask

  task automatic tick();
    @(negedge HCLK); #1;
  endtask

  task automatic clear_logs();
    wlog_a.delete(); wlog_d.delete(); wlog_s.delete(); rlog.delete();
    ntrans = 0; first_ra = -1;
    for (int c = 0; c < NCH; c++) done_cnt[c] = 0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0; tick(); tick(); HRESETn = 1'b1; tick(); clear_logs();
  endtask

  task automatic set_cfg(input int ch, input logic [31:0] sa, input logic [31:0] da,
                         input logic [2:0] ss, input logic [2:0] ds, input logic [2:0] si,
                         input logic [2:0] di, input logic [7:0] bs, input logic [7:0] bc,
                         input logic wfi, input logic [2:0] irq);
    ch_saddr[32*ch +: 32] = sa; ch_daddr[32*ch +: 32] = da;
    ch_ssize[3*ch +: 3] = ss;   ch_dsize[3*ch +: 3] = ds;
    ch_sinc[3*ch +: 3] = si;    ch_dinc[3*ch +: 3] = di;
    ch_bsize[8*ch +: 8] = bs;   ch_bcount[8*ch +: 8] = bc;
    ch_wfi[ch] = wfi;           ch_irqsrc[3*ch +: 3] = irq;
  endtask

  task automatic pulse_start(input logic [NCH-1:0] m);
    ch_start = m; tick(); ch_start = '0;
  endtask

  task automatic wait_done(input int ch, input int maxc, output int dcyc);
    bit ok = 0;
    dcyc = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (ch_done[ch]) begin ok = 1; dcyc = cyc; break; end
    end
    check($sformatf("ch%0d done within bound", ch), {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_bus(input logic wr, input int maxc);
    bit ok = 0;
    for (int i = 0; i < maxc; i++) begin
      if (HTRANS == 2'b10 && HWRITE == wr) begin ok = 1; break; end
      tick();
    end
    check($sformatf("address phase wr=%0d seen", wr), {31'd0, ok}, 32'd1);
  endtask

  typedef struct {
    logic [31:0] saddr, daddr;
    logic [2:0]  ssize, dsize, sinc, dinc;
    logic [7:0]  bsize, bcount;
    logic        pat;
    logic [31:0] rdata;
    int          exp_beats;
    logic [31:0] exp_first_a, exp_last_a, exp_last_d;
    int          exp_cycles;
  } vec_t;

  vec_t vt[6];

  initial begin
    int dcyc, nt, n1;
    logic [31:0] la, ld;
    logic [2:0]  ls;

    vt[0] = '{32'h100, 32'h200, 3'd2, 3'd2, 3'd4, 3'd4, 8'd3, 8'd1, 1'b1, 32'h0,
              8, 32'h200, 32'h21C, 32'hC0DE011C, 40};
    vt[1] = '{32'h103, 32'h400, 3'd0, 3'd0, 3'd1, 3'd1, 8'd0, 8'd0, 1'b0, 32'hAABBCCDD,
              1, 32'h400, 32'h400, 32'hAAAAAAAA, 5};
    vt[2] = '{32'h102, 32'h500, 3'd1, 3'd1, 3'd2, 3'd2, 8'd1, 8'd0, 1'b0, 32'h12345678,
              2, 32'h500, 32'h502, 32'h56785678, 10};
    vt[3] = '{32'h600, 32'h700, 3'd2, 3'd2, 3'd0, 3'd0, 8'd0, 8'd2, 1'b1, 32'h0,
              3, 32'h700, 32'h700, 32'hC0DE0600, 15};
    vt[4] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 3'd2, 3'd2, 3'd4, 3'd4, 8'd2, 8'd0, 1'b1, 32'h0,
              3, 32'hFFFFFFF8, 32'h0, 32'hC0DE0004, 15};
    vt[5] = '{32'h201, 32'h800, 3'd0, 3'd0, 3'd1, 3'd0, 8'd1, 8'd0, 1'b0, 32'hAABBCCDD,
              2, 32'h800, 32'h800, 32'hBBBBBBBB, 10};

    // Reset values while HRESETn is held low
    tick();
    check("rst HTRANS", {30'd0, HTRANS}, 32'd0);
    check("rst HWRITE", {31'd0, HWRITE}, 32'd0);
    check("rst HADDR", HADDR, 32'd0);
    check("rst HSIZE", {29'd0, HSIZE}, 32'd2);
    check("rst HWDATA", HWDATA, 32'd0);
    check("rst ch_busy", {30'd0, ch_busy}, 32'd0);
    check("rst ch_done", {30'd0, ch_done}, 32'd0);
    do_reset();

    for (int i = 0; i < 6; i++) begin
      set_cfg(0, vt[i].saddr, vt[i].daddr, vt[i].ssize, vt[i].dsize, vt[i].sinc,
              vt[i].dinc, vt[i].bsize, vt[i].bcount, 1'b0, 3'd0);
      pat_mode = vt[i].pat; fixed_rdata = vt[i].rdata;
      clear_logs();
      pulse_start(2'b01);
      check($sformatf("v%0d busy after start", i), {31'd0, ch_busy[0]}, 32'd1);
      wait_done(0, 300, dcyc);
      check($sformatf("v%0d busy at done", i), {31'd0, ch_busy[0]}, 32'd0);
      check($sformatf("v%0d cycles", i), dcyc - first_ra + 1, vt[i].exp_cycles);
      check($sformatf("v%0d beats", i), wlog_a.size(), vt[i].exp_beats);
      la = 'x; ld = 'x; ls = 'x;
      if (wlog_a.size() > 0) begin
        check($sformatf("v%0d first daddr", i), wlog_a[0], vt[i].exp_first_a);
        la = wlog_a[wlog_a.size()-1]; ld = wlog_d[wlog_d.size()-1]; ls = wlog_s[wlog_s.size()-1];
      end
      check($sformatf("v%0d last daddr", i), la, vt[i].exp_last_a);
      check($sformatf("v%0d last wdata", i), ld, vt[i].exp_last_d);
      check($sformatf("v%0d write hsize", i), {29'd0, ls}, {29'd0, vt[i].dsize});
      $display("vector %0d: %0d beats, %0d cycles, last write 0x%08h <= 0x%08h",
               i, wlog_a.size(), dcyc - first_ra + 1, la, ld);
    end

    // Round-robin: two channels started together alternate beat by beat
    do_reset();
    pat_mode = 1'b1;
    set_cfg(0, 32'h1000, 32'h2000, 3'd2, 3'd2, 3'd4, 3'd4, 8'd1, 8'd0, 1'b0, 3'd0);
    set_cfg(1, 32'h3000, 32'h4000, 3'd2, 3'd2, 3'd4, 3'd4, 8'd1, 8'd0, 1'b0, 3'd0);
    pulse_start(2'b11);
    for (int i = 0; i < 200 && !(done_cnt[0] > 0 && done_cnt[1] > 0); i++) tick();
    check("rr beats", wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      check("rr w0 addr", wlog_a[0], 32'h2000);
      check("rr w1 addr", wlog_a[1], 32'h4000);
      check("rr w2 addr", wlog_a[2], 32'h2004);
      check("rr w3 addr", wlog_a[3], 32'h4004);
      check("rr w1 data", wlog_d[1], 32'hC0DE3000);
      check("rr w2 data", wlog_d[2], 32'hC0DE1004);
    end
    check("rr ch0 done pulses", done_cnt[0], 1);
    check("rr ch1 done pulses", done_cnt[1], 1);
    $display("round-robin: %0d writes, done0=%0d done1=%0d", wlog_a.size(), done_cnt[0], done_cnt[1]);

    // Request gating: ch1 waits on pirq[3] while ch0 runs
    do_reset();
    pirq = 8'b0000_0100;
    set_cfg(0, 32'h100, 32'h200, 3'd2, 3'd2, 3'd4, 3'd4, 8'd3, 8'd0, 1'b0, 3'd0);
    set_cfg(1, 32'h5000, 32'h6000, 3'd2, 3'd2, 3'd4, 3'd4, 8'd1, 8'd0, 1'b1, 3'd3);
    pulse_start(2'b11);
    wait_done(0, 200, dcyc);
    for (int i = 0; i < 5; i++) tick();
    n1 = 0;
    foreach (rlog[k]) if (rlog[k][15:12] == 4'h5) n1++;
    check("wfi gated reads", n1, 0);
    check("wfi ch0 beats", wlog_a.size(), 4);
    check("wfi ch1 still busy", {31'd0, ch_busy[1]}, 32'd1);
    pirq[3] = 1'b1;
    wait_done(1, 200, dcyc);
    check("wfi total beats", wlog_a.size(), 6);
    if (wlog_a.size() == 6) begin
      check("wfi ch1 last addr", wlog_a[5], 32'h6004);
      check("wfi ch1 last data", wlog_d[5], 32'hC0DE5004);
    end
    $display("wfi: gated reads=%0d, total writes=%0d", n1, wlog_a.size());
    pirq = '0;

    // Start and abort together on an idle channel: abort wins
    do_reset();
    ch_start = 2'b01; ch_abort = 2'b01; tick(); ch_start = '0; ch_abort = '0;
    for (int i = 0; i < 5; i++) tick();
    check("start+abort busy", {31'd0, ch_busy[0]}, 32'd0);
    check("start+abort no bus", ntrans, 0);
    $display("start+abort: busy=%0d transfers=%0d", ch_busy[0], ntrans);

    // Wait states in RA and RD
    do_reset();
    pat_mode = 1'b0; fixed_rdata = 32'hDEADBEEF; HREADY = 1'b0;
    set_cfg(0, 32'h40, 32'h80, 3'd2, 3'd2, 3'd4, 3'd4, 8'd0, 8'd0, 1'b0, 3'd0);
    pulse_start(2'b01);
    wait_bus(1'b0, 20);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("RA stall %0d HADDR", i), HADDR, 32'h40);
      check($sformatf("RA stall %0d HTRANS", i), {30'd0, HTRANS}, 32'd2);
      tick();
    end
    HREADY = 1'b1; tick(); HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("RD stall %0d HTRANS", i), {30'd0, HTRANS}, 32'd0);
      tick();
    end
    fixed_rdata = 32'h5A5A5A5A; HREADY = 1'b1; tick(); fixed_rdata = 32'hDEADBEEF;
    check("stall WA HTRANS", {30'd0, HTRANS}, 32'd2);
    check("stall WA HADDR", HADDR, 32'h80);
    check("stall WA HWRITE", {31'd0, HWRITE}, 32'd1);
    wait_done(0, 50, dcyc);
    check("stall wdata", (wlog_d.size() > 0) ? wlog_d[0] : 32'hx, 32'h5A5A5A5A);
    $display("stall: write data 0x%08h", (wlog_d.size() > 0) ? wlog_d[0] : 32'h0);

    // Abort during WA: the write completes, busy drops, no done pulse
    do_reset();
    pat_mode = 1'b1;
    set_cfg(0, 32'h100, 32'h200, 3'd2, 3'd2, 3'd4, 3'd4, 8'd3, 8'd0, 1'b0, 3'd0);
    pulse_start(2'b01);
    wait_bus(1'b1, 30);
    ch_abort = 2'b01; tick(); ch_abort = '0;
    check("abort busy in WD", {31'd0, ch_busy[0]}, 32'd1);
    tick();
    check("abort busy after beat", {31'd0, ch_busy[0]}, 32'd0);
    check("abort write completed", wlog_a.size(), 1);
    for (int i = 0; i < 10; i++) tick();
    check("abort bus quiet", ntrans, 2);
    check("abort no done", done_cnt[0], 0);
    $display("abort: writes=%0d transfers=%0d done=%0d", wlog_a.size(), ntrans, done_cnt[0]);

    // Asynchronous reset in the middle of a stalled read data phase
    clear_logs();
    pulse_start(2'b01);
    wait_bus(1'b0, 20);
    tick(); HREADY = 1'b0; tick();
    check("pre-reset HADDR in RD", HADDR, 32'h100);
    HRESETn = 1'b0; #1;
    check("async rst HTRANS", {30'd0, HTRANS}, 32'd0);
    check("async rst HADDR", HADDR, 32'd0);
    check("async rst ch_busy", {31'd0, ch_busy[0]}, 32'd0);
    check("async rst HSIZE", {29'd0, HSIZE}, 32'd2);
    tick(); tick(); HRESETn = 1'b1; HREADY = 1'b1;
    nt = ntrans;
    for (int i = 0; i < 10; i++) tick();
    check("post-reset no bus", ntrans, nt);
    $display("reset mid-RD: busy=%0d transfers after release=%0d", ch_busy[0], ntrans - nt);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
